// File: rtl/pkt_pkg.sv
// Shared packet-bus definitions used by the transmitter and the receiver.
// Holds default field widths, the bus beat structs, the credit type and the
// even-parity helper that produces or checks the ECC bit.
package pkt_pkg;

  localparam int unsigned PKT_PAYLOAD_W = 32;
  localparam int unsigned PKT_FLAGS_W   = 4;
  localparam int unsigned PKT_ADDR_W    = 4;
  localparam int unsigned PKT_ID_W      = 4;
  localparam int unsigned PKT_DEPTH     = 4;
  localparam int unsigned PKT_CNT_W     = 8;

  // Data part of one bus beat.
  typedef struct packed {
    logic [PKT_FLAGS_W-1:0]   flags;
    logic [PKT_ADDR_W-1:0]    addr;
    logic [PKT_PAYLOAD_W-1:0] payload;
    logic                     ecc;
  } pkt_data_t;

  // Control part of one bus beat.
  typedef struct packed {
    logic [PKT_ID_W-1:0] id;
    logic                eop;
  } pkt_ctl_t;

  // Credits returned per cycle: 0, 1 or 2.
  typedef logic [1:0] credit_t;

  // ECC bit that makes payload plus ECC have an even number of ones.
  function automatic logic even_parity(input logic [PKT_PAYLOAD_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/pkt_rcv_fifo.sv
// First-word fall-through FIFO for accepted packets.
// Ports: clk, rst (sync, active-high), push/wdata write side, pop/rdata read
// side (rdata is the head entry), count (0..DEPTH), full and empty (registered).
// DEPTH must be a power of 2 so the pointers wrap naturally.
module pkt_rcv_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  T                           wdata,
  output T                           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  T                   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count_nxt;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (PTR_W+1)'(1);
      2'b01:   count_nxt = count - (PTR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == (PTR_W+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage is not reset; contents are only read while non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/pkt_rcv.sv
// Packet-bus receive stage: classifies each beat (parity error, address miss,
// accept), buffers accepted beats for the local CPU and returns credits to
// the transmitter for every freed slot or dropped beat.
// Ports: clk, rst (sync, active-high); bus_* beat inputs (credit-controlled,
// no ready); credit (registered, 0..2); cpu_valid/cpu_ready handshake with
// cpu_payload/cpu_flags/cpu_src_id head fields; par_err_cnt/drop_cnt
// saturating counters; overflow sticky flag.
// Optional build macro PKT_RCV_ECC_CHECK_EN enables the parity check; without
// it bus_ecc is ignored and par_err_cnt reads 0.
module pkt_rcv
  import pkt_pkg::*;
#(
  parameter int unsigned       PAYLOAD_W = PKT_PAYLOAD_W,
  parameter int unsigned       FLAGS_W   = PKT_FLAGS_W,
  parameter int unsigned       ADDR_W    = PKT_ADDR_W,
  parameter int unsigned       ID_W      = PKT_ID_W,
  parameter int unsigned       DEPTH     = PKT_DEPTH,
  parameter logic [ADDR_W-1:0] MY_ADDR   = '0,
  parameter int unsigned       CNT_W     = PKT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_rx_valid,
  input  logic [FLAGS_W-1:0]   bus_flags,
  input  logic [ADDR_W-1:0]    bus_addr,
  input  logic [PAYLOAD_W-1:0] bus_payload,
  input  logic                 bus_ecc,
  input  logic [ID_W-1:0]      bus_id,
  input  logic                 bus_eop,
  output logic [1:0]           credit,
  output logic                 cpu_valid,
  input  logic                 cpu_ready,
  output logic [PAYLOAD_W-1:0] cpu_payload,
  output logic [FLAGS_W-1:0]   cpu_flags,
  output logic [ID_W-1:0]      cpu_src_id,
  output logic [CNT_W-1:0]     par_err_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ID_W-1:0]      id;
    logic [FLAGS_W-1:0]   flags;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  logic    par_err_c;
  logic    addr_miss_c;
  logic    accept_c;
  logic    push_c;
  logic    pop_c;
  logic    fifo_full;
  logic    fifo_empty;
  entry_t  wr_entry;
  entry_t  rd_entry;
  logic [CW-1:0] fifo_count_unused;
  logic          eop_unused;

  // eop always equals valid for single-beat packets, so it carries no information.
  assign eop_unused = bus_eop;

  // Beat classification; a parity error outranks an address miss.
  always_comb begin
    par_err_c = 1'b0;
`ifdef PKT_RCV_ECC_CHECK_EN
    par_err_c = bus_rx_valid &&
                (even_parity(PKT_PAYLOAD_W'(bus_payload)) != bus_ecc);
`endif
    addr_miss_c = bus_rx_valid && !par_err_c && (bus_addr != MY_ADDR);
    accept_c    = bus_rx_valid && !par_err_c && !addr_miss_c;
    pop_c       = cpu_valid && cpu_ready;
    // A full FIFO still takes the beat when the head leaves this cycle.
    push_c      = accept_c && (!fifo_full || pop_c);
  end

`ifndef PKT_RCV_ECC_CHECK_EN
  logic ecc_unused;
  assign ecc_unused = bus_ecc;
`endif

  assign wr_entry = '{id: bus_id, flags: bus_flags, payload: bus_payload};

  pkt_rcv_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (fifo_count_unused),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cpu_valid   = !fifo_empty;
  assign cpu_payload = rd_entry.payload;
  assign cpu_flags   = rd_entry.flags;
  assign cpu_src_id  = rd_entry.id;

  // Credits, drop counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit   <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      credit <= credit_t'(pop_c) + credit_t'(par_err_c || addr_miss_c);
      if (addr_miss_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
      if (accept_c && fifo_full && !pop_c) overflow <= 1'b1;
    end
  end

`ifdef PKT_RCV_ECC_CHECK_EN
  // Saturating parity-error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_cnt <= '0;
    end else if (par_err_c && (par_err_cnt != '1)) begin
      par_err_cnt <= par_err_cnt + CNT_W'(1);
    end
  end
`else
  assign par_err_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_rcv.sv
// Directed self-checking bench for pkt_rcv (DEPTH 4, MY_ADDR 0, CNT_W 8).
// Expectations follow the PKT_RCV_ECC_CHECK_EN setting of the build.
module tb_pkt_rcv;
  import pkt_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_rx_valid;
  logic [3:0]  bus_flags;
  logic [3:0]  bus_addr;
  logic [31:0] bus_payload;
  logic        bus_ecc;
  logic [3:0]  bus_id;
  logic        bus_eop;
  logic [1:0]  credit;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_payload;
  logic [3:0]  cpu_flags;
  logic [3:0]  cpu_src_id;
  logic [7:0]  par_err_cnt;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int tx_cred = DEPTH;
  int cred_sum;

`ifdef PKT_RCV_ECC_CHECK_EN
  localparam bit ECC_ON = 1'b1;
`else
  localparam bit ECC_ON = 1'b0;
`endif

  pkt_rcv #(.PAYLOAD_W(32), .FLAGS_W(4), .ADDR_W(4), .ID_W(4), .DEPTH(DEPTH),
            .MY_ADDR(4'h0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus_rx_valid(bus_rx_valid), .bus_flags(bus_flags),
    .bus_addr(bus_addr), .bus_payload(bus_payload), .bus_ecc(bus_ecc),
    .bus_id(bus_id), .bus_eop(bus_eop), .credit(credit), .cpu_valid(cpu_valid),
    .cpu_ready(cpu_ready), .cpu_payload(cpu_payload), .cpu_flags(cpu_flags),
    .cpu_src_id(cpu_src_id), .par_err_cnt(par_err_cnt), .drop_cnt(drop_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Transmitter credit model: spends one per beat sent, regains returned credits.
  always @(posedge clk) begin
    if (rst) tx_cred <= DEPTH;
    else     tx_cred <= tx_cred - int'(bus_rx_valid) + int'(credit);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst && !overflow)
      check("credit_invariant", 32'(tx_cred + int'(credit) + int'(dut.u_fifo.count)), 32'(DEPTH));
  endtask

  task automatic beat(input logic [3:0] addr, input logic [31:0] pl, input logic ecc);
    bus_rx_valid = 1'b1; bus_eop = 1'b1; bus_addr = addr; bus_payload = pl;
    bus_ecc = ecc; bus_flags = pl[3:0]; bus_id = 4'h7;
  endtask

  task automatic idle();
    bus_rx_valid = 1'b0; bus_eop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); cpu_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pl [5];
    logic [31:0] wrap_pl [5];
    exp_pl  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    wrap_pl = '{32'hA0, 32'hA5, 32'hC3, 32'h0F, 32'h3C};
    rst = 1'b1; cpu_ready = 1'b0; idle();
    bus_flags = '0; bus_addr = '0; bus_payload = '0; bus_ecc = 1'b0; bus_id = '0;
    do_reset();

    // Reset state
    check("rst_cpu_valid", 32'(cpu_valid), 0);
    check("rst_credit", 32'(credit), 0);
    check("rst_par_err_cnt", 32'(par_err_cnt), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    check("rst_overflow", 32'(overflow), 0);

    // 1: accepted beat, visible next cycle, pop returns one credit
    beat(4'h0, 32'h3, 1'b0); tick(); idle();
    check("t1_cpu_valid", 32'(cpu_valid), 1);
    check("t1_payload", cpu_payload, 32'h3);
    check("t1_flags", 32'(cpu_flags), 32'h3);
    check("t1_src_id", 32'(cpu_src_id), 32'h7);
    check("t1_credit_before_pop", 32'(credit), 0);
    cpu_ready = 1'b1; tick(); cpu_ready = 1'b0;
    check("t1_credit_after_pop", 32'(credit), 1);
    check("t1_empty_after_pop", 32'(cpu_valid), 0);
    tick();
    check("t1_credit_idle", 32'(credit), 0);

    // 2: bad parity beat
    beat(4'h0, 32'h1, 1'b0); tick(); idle();
    check("t2_cpu_valid", 32'(cpu_valid), ECC_ON ? 0 : 1);
    check("t2_par_err_cnt", 32'(par_err_cnt), ECC_ON ? 1 : 0);
    check("t2_credit", 32'(credit), ECC_ON ? 1 : 0);
    if (!ECC_ON) begin
      check("t2_payload", cpu_payload, 32'h1);
      cpu_ready = 1'b1; tick(); cpu_ready = 1'b0;
      check("t2_pop_credit", 32'(credit), 1);
    end
    tick();

    // 3: address miss together with a pop
    beat(4'h0, 32'h5, 1'b0); tick();
    check("t3_head_valid", 32'(cpu_valid), 1);
    beat(4'h1, 32'h6, 1'b0); cpu_ready = 1'b1; tick(); idle(); cpu_ready = 1'b0;
    check("t3_drop_cnt", 32'(drop_cnt), 1);
    check("t3_credit", 32'(credit), 2);
    check("t3_cpu_valid", 32'(cpu_valid), 0);
    tick();
    check("t3_credit_idle", 32'(credit), 0);

    // 4: five beats into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      beat(4'h0, exp_pl[i], 1'b0); tick();
      check("t4_fill_credit", 32'(credit), 0);
      check("t4_overflow", 32'(overflow), (i == 4) ? 1 : 0);
    end
    idle();
    cred_sum = 0;
    cpu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_valid", 32'(cpu_valid), 1);
      check("t4_drain_payload", cpu_payload, exp_pl[i]);
      tick();
      cred_sum += int'(credit);
    end
    cpu_ready = 1'b0;
    tick();
    cred_sum += int'(credit);
    check("t4_drain_empty", 32'(cpu_valid), 0);
    check("t4_total_credits", 32'(cred_sum), 4);
    check("t4_overflow_sticky", 32'(overflow), 1);

    // 5: full FIFO with push and pop in the same cycle
    do_reset();
    check("t5_overflow_cleared", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      beat(4'h0, wrap_pl[i], 1'b0); tick();
    end
    beat(4'h0, wrap_pl[4], 1'b0); cpu_ready = 1'b1; tick(); idle(); cpu_ready = 1'b0;
    check("t5_credit", 32'(credit), 1);
    check("t5_overflow", 32'(overflow), 0);
    check("t5_full_count", 32'(dut.u_fifo.count), 4);
    cpu_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("t5_drain_payload", cpu_payload, wrap_pl[i]);
      tick();
    end
    cpu_ready = 1'b0;
    check("t5_drain_empty", 32'(cpu_valid), 0);

    // 6: saturating parity-error counter, then reset mid-stream
    tick();
    beat(4'h2, 32'h3, 1'b0); tick();
    check("t6_drop_cnt", 32'(drop_cnt), 1);
    cpu_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      beat(4'h0, 32'h1, 1'b0); tick();
    end
    check("t6_par_255", 32'(par_err_cnt), ECC_ON ? 32'hFF : 0);
    beat(4'h0, 32'h1, 1'b0); tick();
    check("t6_par_256", 32'(par_err_cnt), ECC_ON ? 32'hFF : 0);
    beat(4'h0, 32'h1, 1'b0); tick();
    check("t6_par_257", 32'(par_err_cnt), ECC_ON ? 32'hFF : 0);
    rst = 1'b1; tick();
    check("t6_rst_par", 32'(par_err_cnt), 0);
    check("t6_rst_drop", 32'(drop_cnt), 0);
    check("t6_rst_cpu_valid", 32'(cpu_valid), 0);
    check("t6_rst_credit", 32'(credit), 0);
    rst = 1'b0; idle(); cpu_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
